bip_control_unit: RTL
=====================

Name: bip_control_unit

Overview:
- Instruction sequencer for the 16-bit accumulator CPU.
- Drives the program memory address (PC) and captures the fetched instruction into an instruction register.
- Decodes opcode[15:11] and operand[10:0], then issues one-cycle control strobes to the data memory, ALU mux and accumulator.
- Sits between program_memory and the datapath (accumulator, ALU, data RAM). Owns the PC, the run/halt state and a cycle counter.

Parameters:
ADDR_LENGTH, 11, width of PC, operand field and data-memory address
DATA_LENGTH, 16, instruction width; opcode = top 5 bits
CNT_LENGTH, 32, width of executed-cycle counter

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse: begin execution from PC=0
instruction  in  DATA_LENGTH  program memory read data, valid the cycle after pm_addr is presented
pm_addr  out  ADDR_LENGTH  program memory address (= PC)
pm_wr  out  1  program memory write enable; constant 0
dm_addr  out  ADDR_LENGTH  data memory address (= IR operand)
dm_rd  out  1  data memory read strobe
dm_wr  out  1  data memory write strobe (store accumulator)
operand  out  ADDR_LENGTH  IR operand, for immediate sign-extension in datapath
sel_a  out  2  acc input mux: 0=data mem, 1=immediate, 2=ALU result
sel_b  out  1  ALU B mux: 0=data mem, 1=immediate
alu_op  out  1  0=add, 1=subtract
wr_acc  out  1  accumulator write enable
busy  out  1  high from start until HALTED
halted  out  1  high in HALTED state
cycle_count  out  CNT_LENGTH  clk cycles spent while busy

Behaviour:
- Reset (async, any state): state=IDLE; PC=0; IR=0; cycle_count=0. All strobes, busy and halted = 0; sel_a=0, sel_b=0, alu_op=0.
- Opcodes:
  - 00000 HLT
  - 00001 STO
  - 00010 LD
  - 00011 LDI
  - 00100 ADD
  - 00101 ADDI
  - 00110 SUB
  - 00111 SUBI
  - all others: NOP (PC advances, no strobes).
- States:
  - IDLE: wait for start; start -> FETCH with PC=0.
  - FETCH: pm_addr=PC. Program memory registers the word (1-cycle read latency). -> DECODE.
  - DECODE: IR <= instruction. -> EXEC.
  - EXEC: one cycle of strobes from IR; PC <= PC+1 except on HLT.
    - HLT -> HALTED, PC unchanged.
    - STO: dm_wr=1 -> FETCH.
    - LDI: wr_acc=1, sel_a=1 -> FETCH.
    - ADDI/SUBI: sel_b=1, alu_op, sel_a=2, wr_acc=1 -> FETCH.
    - LD/ADD/SUB: dm_rd=1, no acc write -> WB.
    - NOP -> FETCH.
  - WB: data RAM output valid. LD: sel_a=0, wr_acc=1. ADD/SUB: sel_b=0, alu_op, sel_a=2, wr_acc=1. -> FETCH.
  - HALTED: halted=1, busy=0. start -> FETCH with PC=0 and cycle_count=0.
- Latency per instruction: 3 cycles (HLT, STO, immediates, NOP); 4 cycles (LD, ADD, SUB).
- Strobes are registered-state decodes and last exactly one cycle.
- dm_addr and operand are stable from DECODE+1 through WB.
- PC wraps from 2^ADDR_LENGTH-1 to 0 without halting.
- start while busy is ignored. start in the same cycle as reset is ignored.
- cycle_count increments every cycle busy=1 and saturates at all-ones.
- Reset mid-instruction aborts it: no strobe is emitted after reset asserts.

Decomposition:
- Shared package bip_defs: opcode localparams (OP_HLT..OP_SUBI), SEL_A_* and SEL_B_* encodings, ALU_ADD/ALU_SUB, state encodings.
- One sub-module is natural: bip_decoder, purely combinational opcode -> {is_hlt, is_sto, uses_dm, uses_imm, writes_acc, alu_op}. The FSM, PC, IR and counter stay in bip_control_unit.

Test Plan:
- Reset, then start with program {0x1001 LD 1, 0x2002 ADD 2, 0x0800 STO 0, 0x0000 HLT} -> strobes in order:
  - dm_rd@1 / wr_acc@1 sel_a=0
  - dm_rd@2 / wr_acc@2 sel_a=2 alu_op=0
  - dm_wr@0
  - halted=1 with PC=3 and cycle_count=4+4+3+3=14.
- Program {0x1805 LDI 5, 0x3803 SUBI 3, HLT} -> LDI: wr_acc with sel_a=1, operand=5. SUBI: sel_b=1, alu_op=1, sel_a=2. Halt after 9 busy cycles.
- Undefined opcode 0xF800 at PC=0, then HLT -> no dm or acc strobes, PC=1, halted after 6 cycles.
- PC=2047 holding NOP, PC=0 holding HLT (run started by preloading) -> pm_addr wraps 2047->0, halted=1.
- Assert rst during WB of an ADD -> wr_acc never pulses; outputs return to reset values the same cycle. Next start executes from PC=0.
- start pulse while busy -> ignored, PC sequence unchanged. start while halted -> PC=0, cycle_count=0, program reruns identically.

Source files
------------

// File: rtl/bip_defs.sv
// Shared definitions for the BIP accumulator CPU control path.
// Opcode values, accumulator/ALU mux encodings, ALU operation codes and the
// sequencer state encoding.
package bip_defs;

  localparam int unsigned OPCODE_LENGTH = 5;

  localparam logic [4:0] OP_HLT  = 5'b00000;
  localparam logic [4:0] OP_STO  = 5'b00001;
  localparam logic [4:0] OP_LD   = 5'b00010;
  localparam logic [4:0] OP_LDI  = 5'b00011;
  localparam logic [4:0] OP_ADD  = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SUBI = 5'b00111;

  // Accumulator input mux
  localparam logic [1:0] SEL_A_DM  = 2'd0;
  localparam logic [1:0] SEL_A_IMM = 2'd1;
  localparam logic [1:0] SEL_A_ALU = 2'd2;

  // ALU B operand mux
  localparam logic SEL_B_DM  = 1'b0;
  localparam logic SEL_B_IMM = 1'b1;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StWb,
    StHalted
  } state_e;

endpackage

// File: rtl/bip_decoder.sv
// Combinational opcode decoder.
// Ports:
//   opcode      in   5-bit opcode field of the instruction register
//   is_hlt      out  HLT
//   is_sto      out  STO
//   uses_dm     out  LD/ADD/SUB: needs a data memory read and a WB cycle
//   uses_imm    out  LDI/ADDI/SUBI: operand is an immediate
//   is_load     out  LD/LDI: accumulator loaded directly, ALU bypassed
//   writes_acc  out  instruction writes the accumulator
//   alu_op      out  ALU_ADD / ALU_SUB
// Unlisted opcodes decode to all zeros (NOP).
module bip_decoder
  import bip_defs::*;
(
  input  logic [OPCODE_LENGTH-1:0] opcode,
  output logic                     is_hlt,
  output logic                     is_sto,
  output logic                     uses_dm,
  output logic                     uses_imm,
  output logic                     is_load,
  output logic                     writes_acc,
  output logic                     alu_op
);

  always_comb begin
    is_hlt     = 1'b0;
    is_sto     = 1'b0;
    uses_dm    = 1'b0;
    uses_imm   = 1'b0;
    is_load    = 1'b0;
    writes_acc = 1'b0;
    alu_op     = ALU_ADD;
    case (opcode)
      OP_HLT:  is_hlt = 1'b1;
      OP_STO:  is_sto = 1'b1;
      OP_LD: begin
        uses_dm    = 1'b1;
        is_load    = 1'b1;
        writes_acc = 1'b1;
      end
      OP_LDI: begin
        uses_imm   = 1'b1;
        is_load    = 1'b1;
        writes_acc = 1'b1;
      end
      OP_ADD: begin
        uses_dm    = 1'b1;
        writes_acc = 1'b1;
      end
      OP_ADDI: begin
        uses_imm   = 1'b1;
        writes_acc = 1'b1;
      end
      OP_SUB: begin
        uses_dm    = 1'b1;
        writes_acc = 1'b1;
        alu_op     = ALU_SUB;
      end
      OP_SUBI: begin
        uses_imm   = 1'b1;
        writes_acc = 1'b1;
        alu_op     = ALU_SUB;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/bip_control_unit.sv
// Instruction sequencer for the 16-bit accumulator CPU.
// Owns PC, IR, run/halt state and the busy-cycle counter; issues one-cycle
// control strobes to data memory, ALU muxes and accumulator.
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   start         pulse: run from PC=0 (ignored while busy)
//   instruction   program memory data, valid the cycle after pm_addr
//   pm_addr/pm_wr program memory address (PC) / write enable (always 0)
//   dm_addr       data memory address (IR operand)
//   dm_rd/dm_wr   data memory read / write strobes
//   operand       IR operand for immediate sign-extension
//   sel_a/sel_b   accumulator input mux / ALU B mux
//   alu_op        0 add, 1 subtract
//   wr_acc        accumulator write enable
//   busy/halted   running / stopped on HLT
//   cycle_count   saturating count of busy cycles
module bip_control_unit
  import bip_defs::*;
#(
  parameter int unsigned ADDR_LENGTH = 11,
  parameter int unsigned DATA_LENGTH = 16,
  parameter int unsigned CNT_LENGTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [DATA_LENGTH-1:0] instruction,
  output logic [ADDR_LENGTH-1:0] pm_addr,
  output logic                   pm_wr,
  output logic [ADDR_LENGTH-1:0] dm_addr,
  output logic                   dm_rd,
  output logic                   dm_wr,
  output logic [ADDR_LENGTH-1:0] operand,
  output logic [1:0]             sel_a,
  output logic                   sel_b,
  output logic                   alu_op,
  output logic                   wr_acc,
  output logic                   busy,
  output logic                   halted,
  output logic [CNT_LENGTH-1:0]  cycle_count
);

  state_e                 state_q, state_d;
  logic [ADDR_LENGTH-1:0] pc_q, pc_d;
  logic [DATA_LENGTH-1:0] ir_q, ir_d;
  logic [CNT_LENGTH-1:0]  cnt_q, cnt_d;

  logic is_hlt, is_sto, uses_dm, uses_imm, is_load, writes_acc, dec_alu_op;

  bip_decoder u_decoder (
    .opcode     (ir_q[DATA_LENGTH-1 -: OPCODE_LENGTH]),
    .is_hlt     (is_hlt),
    .is_sto     (is_sto),
    .uses_dm    (uses_dm),
    .uses_imm   (uses_imm),
    .is_load    (is_load),
    .writes_acc (writes_acc),
    .alu_op     (dec_alu_op)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      pc_q    <= '0;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy        = (state_q == StFetch) || (state_q == StDecode) ||
                       (state_q == StExec)  || (state_q == StWb);
  assign halted      = (state_q == StHalted);
  assign pm_addr     = pc_q;
  assign pm_wr       = 1'b0;
  assign operand     = ir_q[ADDR_LENGTH-1:0];
  assign dm_addr     = ir_q[ADDR_LENGTH-1:0];
  assign cycle_count = cnt_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    dm_rd   = 1'b0;
    dm_wr   = 1'b0;
    wr_acc  = 1'b0;
    sel_a   = SEL_A_DM;
    sel_b   = SEL_B_DM;
    alu_op  = ALU_ADD;

    if (busy && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_LENGTH'(1);
    end

    unique case (state_q)
      StIdle, StHalted: begin
        if (start) begin
          state_d = StFetch;
          pc_d    = '0;
          cnt_d   = '0;
        end
      end
      StFetch:  state_d = StDecode;
      StDecode: begin
        ir_d    = instruction;
        state_d = StExec;
      end
      StExec: begin
        if (is_hlt) begin
          state_d = StHalted;
        end else begin
          pc_d    = pc_q + ADDR_LENGTH'(1);
          state_d = uses_dm ? StWb : StFetch;
        end
        dm_wr = is_sto;
        dm_rd = uses_dm;
        if (uses_imm) begin
          wr_acc = writes_acc;
          if (is_load) begin
            sel_a = SEL_A_IMM;
          end else begin
            sel_a  = SEL_A_ALU;
            sel_b  = SEL_B_IMM;
            alu_op = dec_alu_op;
          end
        end
      end
      StWb: begin
        // Data RAM output is valid now; commit LD/ADD/SUB result.
        wr_acc  = writes_acc;
        sel_a   = is_load ? SEL_A_DM : SEL_A_ALU;
        alu_op  = is_load ? ALU_ADD : dec_alu_op;
        state_d = StFetch;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule
